// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave controller.
package i2c_pkg;

    localparam logic [6:0] DEF_SLAVE_ADDR  = 7'h50;
    localparam int         DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_t;

    // Upper seven bits of a received address byte compared with our address.
    function automatic logic addr_match(input logic [7:0] byte_in, input logic [6:0] addr);
        return byte_in[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw bus lines and derives SCL edges plus START/STOP events.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   s_scl;
    logic                   scl_d;
    logic                   sda_d;

    assign s_scl = scl_pipe[SYNC_STAGES-1];
    assign s_sda = sda_pipe[SYNC_STAGES-1];

    // Synchronizer chains plus one-cycle-delayed copies; idle bus level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            scl_d    <= s_scl;
            sda_d    <= s_sda;
        end
    end

    assign scl_rise  =  s_scl & ~scl_d;
    assign scl_fall  = ~s_scl &  scl_d;
    // SDA moving while SCL stays high is a bus condition, never data.
    assign start_det =  s_scl & scl_d &  sda_d & ~s_sda;
    assign stop_det  =  s_scl & scl_d & ~sda_d &  s_sda;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave: address match, byte write/read with ACK handling, no clock stretching.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
    parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic s_sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .s_sda    (s_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_t state_q, state_n;
    logic [2:0] cnt_q, cnt_n;
    logic [7:0] shift_q, shift_n;
    logic [7:0] tx_q, tx_n;
    logic       rw_q, rw_n;
    logic       ack_ph_q, ack_ph_n;   // ACK slot: 0 = before drive, 1 = driving / master ACK seen
    logic       sda_q, sda_n;
    logic       busy_q, busy_n;
    logic       wr_valid_q, wr_valid_n;
    logic [7:0] wr_data_q, wr_data_n;
    logic       rd_req_q, rd_req_n;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], s_sda};

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            shift_q    <= shift_n;
            tx_q       <= tx_n;
            rw_q       <= rw_n;
            ack_ph_q   <= ack_ph_n;
            sda_q      <= sda_n;
            busy_q     <= busy_n;
            wr_valid_q <= wr_valid_n;
            wr_data_q  <= wr_data_n;
            rd_req_q   <= rd_req_n;
        end
    end

    // Next-state and output logic; START outranks STOP, both outrank bit activity.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        shift_n    = shift_q;
        tx_n       = tx_q;
        rw_n       = rw_q;
        ack_ph_n   = ack_ph_q;
        sda_n      = sda_q;
        busy_n     = busy_q;
        wr_valid_n = 1'b0;
        wr_data_n  = wr_data_q;
        rd_req_n   = 1'b0;

        if (start_det) begin
            state_n  = ADDR;
            cnt_n    = '0;
            shift_n  = '0;
            ack_ph_n = 1'b0;
            sda_n    = 1'b1;
        end else if (stop_det) begin
            state_n  = IDLE;
            sda_n    = 1'b1;
            busy_n   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_n = shift_in;
                    cnt_n   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ack_ph_n = 1'b0;
                        if (addr_match(shift_in, SLAVE_ADDR)) begin
                            rw_n    = shift_in[0];
                            busy_n  = 1'b1;
                            state_n = ADDR_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            sda_n   = 1'b1;
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_n    = 1'b0;
                        ack_ph_n = 1'b1;
                    end else begin
                        sda_n    = 1'b1;
                        ack_ph_n = 1'b0;
                        if (rw_q) begin
                            rd_req_n = 1'b1;
                            state_n  = READ;
                        end else begin
                            state_n  = WRITE;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    shift_n = shift_in;
                    cnt_n   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_data_n  = shift_in;
                        wr_valid_n = 1'b1;
                        ack_ph_n   = 1'b0;
                        state_n    = WRITE_ACK;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_n    = 1'b0;
                        ack_ph_n = 1'b1;
                    end else begin
                        sda_n    = 1'b1;
                        ack_ph_n = 1'b0;
                        state_n  = WRITE;
                    end
                end
                READ: begin
                    // The byte arrives in the rd_req cycle; its MSB goes out right away.
                    if (rd_req_q) begin
                        tx_n  = rd_data;
                        sda_n = rd_data[7];
                    end else if (scl_fall) begin
                        cnt_n = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            sda_n    = 1'b1;
                            ack_ph_n = 1'b0;
                            state_n  = READ_ACK;
                        end else begin
                            tx_n  = {tx_q[6:0], 1'b0};
                            sda_n = tx_q[6];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (s_sda) begin
                            busy_n  = 1'b0;
                            state_n = IGNORE;
                        end else begin
                            ack_ph_n = 1'b1;
                        end
                    end else if (scl_fall && ack_ph_q) begin
                        ack_ph_n = 1'b0;
                        rd_req_n = 1'b1;
                        state_n  = READ;
                    end
                end
                IGNORE:  sda_n = 1'b1;
                default: ;
            endcase
        end
    end

    assign scl_out  = 1'b1;
    assign sda_out  = sda_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign rd_req   = rd_req_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench: a bit-banged I2C master on a wired-AND bus against the slave.
module tb_i2c_slave_ctrl;

    localparam int Q = 8;   // clk cycles per SCL phase

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in, scl_out, sda_out;
    logic       wr_valid, rd_req, busy;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;

    int errors = 0;
    int checks = 0;
    int wr_tot = 0, rd_tot = 0, both_tot = 0;
    logic [7:0] last_wr = 8'h00;

    assign scl_in = scl_m & scl_out;
    assign sda_in = sda_m & sda_out;

    always #5 clk = ~clk;

    i2c_slave_ctrl dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_out(scl_out), .sda_out(sda_out), .wr_valid(wr_valid),
        .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
    );

    always @(posedge clk) begin
        if (wr_valid) begin
            wr_tot  = wr_tot + 1;
            last_wr = wr_data;
        end
        if (rd_req) rd_tot = rd_tot + 1;
        if (wr_valid && rd_req) both_tot = both_tot + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        wait_cyc(2); sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(2);
    endtask

    task automatic i2c_stop;
        wait_cyc(2); sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        sda_m = 1'b1; wait_cyc(Q);
    endtask

    task automatic send_bit(input logic b);
        wait_cyc(2); sda_m = b; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b0;
    endtask

    // Eight data bits then the 9th clock with SDA released; ack = bus level seen.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_cyc(2); sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q/2);
        ack = sda_in; wait_cyc(Q/2);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(2); sda_m = 1'b1; wait_cyc(Q);
            scl_m = 1'b1; wait_cyc(Q/2);
            b[i] = sda_in; wait_cyc(Q/2);
            scl_m = 1'b0;
        end
        wait_cyc(2); sda_m = m_ack; wait_cyc(Q);
        scl_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b0; wait_cyc(2);
        sda_m = 1'b1; wait_cyc(Q);
    endtask

    task automatic test_reset;
        rst = 1'b1; wait_cyc(3);
        checks += 6;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1", sda_out); end
        if (scl_out !== 1'b1) begin errors++; $display("FAIL reset_scl got=%b exp=1", scl_out); end
        if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; wait_cyc(5);
    endtask

    task automatic test_write;
        logic a0, a1;
        int w0, r0;
        w0 = wr_tot; r0 = rd_tot;
        i2c_start;
        write_byte(8'hA0, a0);
        checks += 2;
        if (a0 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%b exp=0", a0); end
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_on got=%b exp=1", busy); end
        write_byte(8'h3C, a1);
        i2c_stop; wait_cyc(4);
        checks += 5;
        if (a1 !== 1'b0) begin errors++; $display("FAIL wr_data_ack got=%b exp=0", a1); end
        if (wr_tot - w0 != 1) begin errors++; $display("FAIL wr_count got=%0d exp=1", wr_tot - w0); end
        if (last_wr !== 8'h3C) begin errors++; $display("FAIL wr_data got=%h exp=3c", last_wr); end
        if (rd_tot != r0) begin errors++; $display("FAIL wr_no_rd got=%0d exp=0", rd_tot - r0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_off got=%b exp=0", busy); end
    endtask

    task automatic test_read;
        logic a0;
        logic [7:0] b0, b1;
        int w0, r0;
        w0 = wr_tot; r0 = rd_tot;
        rd_data = 8'h96;
        i2c_start;
        write_byte(8'hA1, a0);
        rd_data = 8'h5A;
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        wait_cyc(4);
        checks += 6;
        if (a0 !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got=%b exp=0", a0); end
        if (b0 !== 8'h96) begin errors++; $display("FAIL rd_byte0 got=%h exp=96", b0); end
        if (b1 !== 8'h5A) begin errors++; $display("FAIL rd_byte1 got=%h exp=5a", b1); end
        if (rd_tot - r0 != 2) begin errors++; $display("FAIL rd_req_count got=%0d exp=2", rd_tot - r0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy got=%b exp=0", busy); end
        if (sda_out !== 1'b1) begin errors++; $display("FAIL rd_nack_release got=%b exp=1", sda_out); end
        i2c_stop; wait_cyc(4);
        checks += 1;
        if (wr_tot != w0) begin errors++; $display("FAIL rd_no_wr got=%0d exp=0", wr_tot - w0); end
    endtask

    task automatic test_mismatch;
        logic a0, a1;
        int w0, r0;
        w0 = wr_tot; r0 = rd_tot;
        i2c_start;
        write_byte(8'hA2, a0);
        checks += 2;
        if (a0 !== 1'b1) begin errors++; $display("FAIL mm_addr_nack got=%b exp=1", a0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got=%b exp=0", busy); end
        write_byte(8'h00, a1);
        checks += 3;
        if (a1 !== 1'b1) begin errors++; $display("FAIL mm_data_nack got=%b exp=1", a1); end
        if (wr_tot != w0) begin errors++; $display("FAIL mm_no_wr got=%0d exp=0", wr_tot - w0); end
        if (rd_tot != r0) begin errors++; $display("FAIL mm_no_rd got=%0d exp=0", rd_tot - r0); end
        i2c_stop; wait_cyc(4);
    endtask

    task automatic test_repeated_start;
        logic a0, a1, a2;
        logic [7:0] b0;
        int w0, r0;
        w0 = wr_tot; r0 = rd_tot;
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h11, a1);
        rd_data = 8'h77;
        i2c_start;
        write_byte(8'hA1, a2);
        read_byte(1'b1, b0);
        i2c_stop; wait_cyc(4);
        checks += 6;
        if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL rs_write_acks got=%b exp=00", {a0, a1}); end
        if (a2 !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got=%b exp=0", a2); end
        if (wr_tot - w0 != 1) begin errors++; $display("FAIL rs_wr_count got=%0d exp=1", wr_tot - w0); end
        if (last_wr !== 8'h11) begin errors++; $display("FAIL rs_wr_data got=%h exp=11", last_wr); end
        if (rd_tot - r0 != 1) begin errors++; $display("FAIL rs_rd_count got=%0d exp=1", rd_tot - r0); end
        if (b0 !== 8'h77) begin errors++; $display("FAIL rs_rd_byte got=%h exp=77", b0); end
    endtask

    task automatic test_reset_mid;
        logic a0, a1;
        int w0, r0;
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA0 >> i) & 8'h01));
        wait_cyc(2); sda_m = 1'b1; wait_cyc(Q/2);
        checks += 1;
        if (sda_out !== 1'b0) begin errors++; $display("FAIL rm_ack_driven got=%b exp=0", sda_out); end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL rm_async_release got=%b exp=1", sda_out); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        wait_cyc(3);
        rst = 1'b0;
        w0 = wr_tot; r0 = rd_tot;
        wait_cyc(Q);
        // Address clocked without a START must be ignored.
        write_byte(8'hA0, a0);
        checks += 3;
        if (a0 !== 1'b1) begin errors++; $display("FAIL rm_idle_no_ack got=%b exp=1", a0); end
        if (wr_tot != w0 || rd_tot != r0) begin
            errors++; $display("FAIL rm_no_pulses got wr=%0d rd=%0d exp=0", wr_tot - w0, rd_tot - r0);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle_busy got=%b exp=0", busy); end
        i2c_stop;
        i2c_start;
        write_byte(8'hA0, a1);
        i2c_stop; wait_cyc(4);
        checks += 1;
        if (a1 !== 1'b0) begin errors++; $display("FAIL rm_fresh_start_ack got=%b exp=0", a1); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_mismatch;
        test_repeated_start;
        test_reset_mid;
        checks += 2;
        if (both_tot != 0) begin errors++; $display("FAIL pulse_overlap got=%0d exp=0", both_tot); end
        if (scl_out !== 1'b1) begin errors++; $display("FAIL scl_held got=%b exp=1", scl_out); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this slave acknowledges.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl_in/sda_in (minimum 2).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 scl_in  input  1  resolved bus SCL level from the open-drain interface.
REQ-006 sda_in  input  1  resolved bus SDA level.
REQ-007 scl_out  output  1  SCL drive; 1 = release, 0 = pull low; held at 1 (no clock stretching).
REQ-008 sda_out  output  1  SDA drive; 1 = release, 0 = pull low.
REQ-009 wr_valid  output  1  one-cycle pulse when a master-written data byte is complete.
REQ-010 wr_data  output  8  received byte; valid while wr_valid = 1, held otherwise.
REQ-011 rd_req  output  1  one-cycle pulse requesting the next byte for the master.
REQ-012 rd_data  input  8  byte to transmit; sampled in the rd_req cycle.
REQ-013 busy  output  1  high from an address-matched START until STOP, mismatch or NACK.

Function
REQ-014 SHALL pass scl_in/sda_in through SYNC_STAGES flops (reset value 1); all later logic uses the synchronized levels s_scl/s_sda plus one-cycle-delayed copies for edge detection.
REQ-015 SHALL detect START as s_sda falling while s_scl = 1, and STOP as s_sda rising while s_scl = 1.
REQ-016 SHALL use states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-017 START in any state (repeated START included) SHALL clear the bit counter, release sda_out and go to ADDR.
REQ-018 STOP in any state SHALL release sda_out, deassert busy and go to IDLE; START takes priority if both are flagged in the same cycle.
REQ-019 SHALL sample s_sda into the shift register MSB first on each s_scl rising edge; a 3-bit counter counts bits and wraps at 8.
REQ-020 ADDR: after the 8th bit, if shift[7:1] == SLAVE_ADDR, SHALL latch R/W = shift[0], set busy and go to ADDR_ACK; otherwise SHALL go to IGNORE with sda_out = 1.
REQ-021 ACK drive: on the s_scl falling edge after the 8th bit SHALL set sda_out = 0, and SHALL release it on the next s_scl falling edge.
REQ-022 Leaving ADDR_ACK with R/W = 0 SHALL enter WRITE; with R/W = 1 SHALL pulse rd_req, load rd_data into the tx shift register and enter READ.
REQ-023 WRITE: after the 8th bit SHALL load wr_data and pulse wr_valid one cycle after the sampling edge, then enter WRITE_ACK; the slave ACKs every write byte.
REQ-024 WRITE_ACK end SHALL return to WRITE for the next byte.
REQ-025 READ: SHALL place tx bit 7 on sda_out (0 drives low, 1 releases) at state entry, then shift on each s_scl falling edge; after the 8th falling edge SHALL release SDA and enter READ_ACK.
REQ-026 READ_ACK: SHALL sample master ACK on the 9th s_scl rising edge; 0 -> on the next falling edge pulse rd_req, reload and re-enter READ; 1 (NACK) -> IGNORE, busy = 0.
REQ-027 IGNORE SHALL hold sda_out = 1 and leave only on START or STOP.
REQ-028 Transitions on SDA while SCL = 1 outside START/STOP detection SHALL NOT alter data; rd_req and wr_valid never assert in the same cycle.

Reset
REQ-029 While rst = 1 SHALL hold: state = IDLE, sda_out = 1, scl_out = 1, wr_valid = 0, wr_data = 8'h00, rd_req = 0, busy = 0, counters/shift = 0, sync flops = 1.
REQ-030 Reset mid-transfer SHALL release the bus immediately (asynchronously); after release, the block waits in IDLE for a fresh START.

Structure
REQ-031 A package i2c_pkg SHALL hold the state enum type and the default-address/sync-depth constants.
REQ-032 A sub-module i2c_bus_sync SHALL implement the synchronizer plus START/STOP and SCL-edge detection.

Verification
REQ-033 START, 0xA0 (addr 0x50, W), 0x3C, STOP -> ACK on both 9th clocks, one wr_valid with wr_data = 8'h3C, busy 1 then 0.
REQ-034 START, 0xA1, rd_data = 8'h96, master ACK, rd_data = 8'h5A, master NACK, STOP -> SDA carries 96 then 5A, exactly two rd_req pulses, IGNORE after NACK.
REQ-035 START, 0xA2 (addr 0x51) -> no ACK (SDA released on 9th clock), busy stays 0, no wr_valid/rd_req until next START.
REQ-036 Write 0xA0, 0x11, then repeated START, 0xA1, NACK, STOP -> wr_data = 8'h11 once, one rd_req, correct return to ADDR.
REQ-037 rst asserted while the slave is driving ACK low -> sda_out = 1 in the same cycle, state IDLE, no pulses until a new START.
